// File: rtl/pipe_addsub_if.sv
// Handshake and data bundle for the segmented pipelined adder/subtractor.
// The slave modport is the adder side; the master modport is the side that
// supplies operands and consumes results.
interface pipe_addsub_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;

    modport master (
        output in_valid,
        output a,
        output b,
        output c_in,
        output sub,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  sum,
        input  c_out,
        input  ovf
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  c_in,
        input  sub,
        input  out_ready,
        output in_ready,
        output out_valid,
        output sum,
        output c_out,
        output ovf
    );
endinterface

// File: rtl/pipe_addsub.sv
// Segmented pipelined adder/subtractor.
// The operands are split into STAGES = WIDTH/SEG segments. Stage k adds
// segment k with the carry registered by stage k-1. Each stage registers:
//   - the partial sum,
//   - the carry out of its segment,
//   - the operand bits not yet consumed.
// Those operand bits are shifted down by SEG, so every stage reads its
// segment from bits [SEG-1:0] of the previous stage's operand registers.
// Subtraction inverts b and the borrow-in once, at entry. After that, the
// pipeline is a plain adder and c_out reads as "no borrow".
// WIDTH must be an integer multiple of SEG.
// The whole pipeline advances together unless the output beat is stalled.
// Bubbles travel through as invalid stages and are never compacted.
module pipe_addsub #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    pipe_addsub_if.slave bus
);

    localparam int STAGES = WIDTH / SEG;
    localparam int LAST   = STAGES - 1;

    // Global stall: the output beat is present and not being taken.
    logic w_stall;

    // Stage-0 operands after add/sub conditioning.
    logic [WIDTH-1:0] w_in_a;
    logic [WIDTH-1:0] w_in_b;
    logic             w_in_cy;

    // Registered state of every stage, gathered so the next stage can read it.
    logic [STAGES-1:0]            w_vld_q;
    logic [STAGES-1:0]            w_cy_q;
    logic [STAGES-1:0][WIDTH-1:0] w_a_q;
    logic [STAGES-1:0][WIDTH-1:0] w_b_q;
    logic [STAGES-1:0][WIDTH-1:0] w_sum_q;

    // Overflow flag, produced by the final stage only.
    logic r_ovf;

    // The final stage's leftover operand registers feed nothing downstream.
    logic w_unused_tail;

    assign w_stall      = w_vld_q[LAST] & ~bus.out_ready;
    assign bus.in_ready = ~w_stall;

    assign w_in_a  = bus.a;
    assign w_in_b  = bus.b ^ {WIDTH{bus.sub}};
    assign w_in_cy = bus.c_in ^ bus.sub;

    assign w_unused_tail = ^{w_a_q[LAST], w_b_q[LAST]};

    assign bus.out_valid = w_vld_q[LAST];
    assign bus.sum       = w_sum_q[LAST];
    assign bus.c_out     = w_cy_q[LAST];
    assign bus.ovf       = r_ovf;

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_stage
            logic [WIDTH-1:0] w_src_a;
            logic [WIDTH-1:0] w_src_b;
            logic [WIDTH-1:0] w_src_sum;
            logic             w_src_cy;
            logic             w_src_vld;
            logic [SEG:0]     w_seg;
            logic [WIDTH-1:0] w_nxt_sum;

            logic             r_vld;
            logic             r_cy;
            logic [WIDTH-1:0] r_a;
            logic [WIDTH-1:0] r_b;
            logic [WIDTH-1:0] r_sum;

            if (k == 0) begin : g_src_in
                assign w_src_a   = w_in_a;
                assign w_src_b   = w_in_b;
                assign w_src_sum = {WIDTH{1'b0}};
                assign w_src_cy  = w_in_cy;
                assign w_src_vld = bus.in_valid;
            end else begin : g_src_prev
                assign w_src_a   = w_a_q[k-1];
                assign w_src_b   = w_b_q[k-1];
                assign w_src_sum = w_sum_q[k-1];
                assign w_src_cy  = w_cy_q[k-1];
                assign w_src_vld = w_vld_q[k-1];
            end

            // The low SEG bits of the incoming operands are always this stage's segment.
            assign w_seg = {1'b0, w_src_a[SEG-1:0]}
                         + {1'b0, w_src_b[SEG-1:0]}
                         + {{SEG{1'b0}}, w_src_cy};

            // Merge this stage's segment result into the partial sum.
            always_comb begin
                w_nxt_sum                 = w_src_sum;
                w_nxt_sum[k*SEG +: SEG]   = w_seg[SEG-1:0];
            end

            // Stage register: valid follows the pipeline; data loads only with a valid beat.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_vld <= 1'b0;
                    r_cy  <= 1'b0;
                    r_a   <= {WIDTH{1'b0}};
                    r_b   <= {WIDTH{1'b0}};
                    r_sum <= {WIDTH{1'b0}};
                end else if (!w_stall) begin
                    r_vld <= w_src_vld;
                    if (w_src_vld) begin
                        r_cy  <= w_seg[SEG];
                        r_a   <= w_src_a >> SEG;
                        r_b   <= w_src_b >> SEG;
                        r_sum <= w_nxt_sum;
                    end
                end
            end

            assign w_vld_q[k] = r_vld;
            assign w_cy_q[k]  = r_cy;
            assign w_a_q[k]   = r_a;
            assign w_b_q[k]   = r_b;
            assign w_sum_q[k] = r_sum;

            if (k == LAST) begin : g_ovf
                // Carry into the MSB is a^b^s at that bit; overflow is it XOR carry out.
                logic w_ovf_nxt;
                assign w_ovf_nxt = w_src_a[SEG-1] ^ w_src_b[SEG-1]
                                 ^ w_seg[SEG-1] ^ w_seg[SEG];

                // Overflow register, loaded alongside the final partial sum.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_ovf <= 1'b0;
                    end else if (!w_stall && w_src_vld) begin
                        r_ovf <= w_ovf_nxt;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_pipe_addsub.sv
// Self-checking bench for pipe_addsub.
// Covers the default 16/4 instance, plus 32/8 and 8/8 instances
// compared against an arithmetic reference model.
module tb_pipe_addsub;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pipe_addsub_if #(.WIDTH(16)) bus16 ();
    pipe_addsub_if #(.WIDTH(32)) bus32 ();
    pipe_addsub_if #(.WIDTH(8))  bus8 ();

    pipe_addsub #(.WIDTH(16), .SEG(4)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
    pipe_addsub #(.WIDTH(32), .SEG(8)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
    pipe_addsub #(.WIDTH(8),  .SEG(8)) u_dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic        sb;
        logic [15:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    vec_t        vecs [10];
    logic [17:0] exp_q [$];
    logic [33:0] exp32 [200];
    logic [9:0]  exp8  [200];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Reference: returns {ovf, c_out, sum[31:0]} for a w-bit operation.
    function automatic logic [33:0] ref_model(input int w, input logic [31:0] a,
                                              input logic [31:0] b, input logic ci,
                                              input logic sb);
        longint mask, half, ua, ub, uc, t, sa, sbv, r;
        logic [31:0] s;
        logic        co, ov;
        mask = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        ua   = longint'(a) & mask;
        ub   = longint'(b) & mask;
        uc   = ci ? 64'sd1 : 64'sd0;
        if (sb) begin
            t  = ua - ub - uc;
            co = (t >= 0);
        end else begin
            t  = ua + ub + uc;
            co = ((t >> w) & 1) != 0;
        end
        s   = 32'(t & mask);
        sa  = (ua >= half) ? ua - (mask + 1) : ua;
        sbv = (ub >= half) ? ub - (mask + 1) : ub;
        r   = sb ? (sa - sbv - uc) : (sa + sbv + uc);
        ov  = (r >= half) || (r < -half);
        return {ov, co, s};
    endfunction

    function automatic logic [17:0] model16(input logic [15:0] a, input logic [15:0] b,
                                            input logic ci, input logic sb);
        logic [33:0] r;
        r = ref_model(16, {16'd0, a}, {16'd0, b}, ci, sb);
        return {r[33], r[32], r[15:0]};
    endfunction

    // Streams nbeats through the 16-bit DUT with a scoreboard.
    // bp: random out_ready. rnd: random operands and bubbles.
    task automatic run_stream(input string tag, input int nbeats, input bit bp, input bit rnd);
        int          sent = 0;
        int          got  = 0;
        int          cycles = 0;
        int          budget;
        bit          held = 1'b0;
        logic [17:0] held_v = 18'd0;
        logic [17:0] exp_v;
        logic        stall;
        budget = nbeats * 4 + 50;
        exp_q.delete();
        while (got < nbeats && cycles < budget) begin
            @(negedge clk);
            bus16.out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            stall = bus16.out_valid && !bus16.out_ready;
            if (bp) check({tag, "_in_ready"}, {63'd0, bus16.in_ready}, {63'd0, !stall});
            if (held) begin
                check({tag, "_stall_hold"},
                      {45'd0, bus16.out_valid, bus16.ovf, bus16.c_out, bus16.sum},
                      {45'd0, 1'b1, held_v});
            end
            if (bus16.out_valid && bus16.out_ready) begin
                if (exp_q.size() == 0) begin
                    check({tag, "_extra_beat"}, 64'd1, 64'd0);
                end else begin
                    exp_v = exp_q.pop_front();
                    check({tag, "_result"}, {46'd0, bus16.ovf, bus16.c_out, bus16.sum},
                          {46'd0, exp_v});
                end
                got++;
            end
            held   = stall;
            held_v = {bus16.ovf, bus16.c_out, bus16.sum};
            if (sent < nbeats && (!rnd || ($urandom_range(0, 3) != 0))) begin
                bus16.in_valid = 1'b1;
                if (rnd) begin
                    bus16.a    = 16'($urandom);
                    bus16.b    = 16'($urandom);
                    bus16.c_in = 1'($urandom_range(0, 1));
                    bus16.sub  = 1'($urandom_range(0, 1));
                end else begin
                    bus16.a    = 16'(sent);
                    bus16.b    = 16'(sent) >> 2;
                    bus16.c_in = 1'b0;
                    bus16.sub  = 1'b0;
                end
                if (bus16.in_ready) begin
                    exp_q.push_back(model16(bus16.a, bus16.b, bus16.c_in, bus16.sub));
                    sent++;
                end
            end else begin
                bus16.in_valid = 1'b0;
            end
            cycles++;
        end
        bus16.in_valid  = 1'b0;
        bus16.out_ready = 1'b1;
        check({tag, "_beats_out"}, 64'(got), 64'(nbeats));
        check({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
        if (!bp && !rnd) check({tag, "_cycles"}, 64'(cycles), 64'(nbeats + 4));
    endtask

    initial begin
        vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[1] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[2] = '{16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[4] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
        vecs[5] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        vecs[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[7] = '{16'h5555, 16'h5555, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[8] = '{16'h000F, 16'h0001, 1'b0, 1'b0, 16'h0010, 1'b0, 1'b0};
        vecs[9] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};

        rst_n = 1'b1;
        bus16.in_valid = 1'b0; bus16.a = 16'd0; bus16.b = 16'd0;
        bus16.c_in = 1'b0; bus16.sub = 1'b0; bus16.out_ready = 1'b1;
        bus32.in_valid = 1'b0; bus32.a = 32'd0; bus32.b = 32'd0;
        bus32.c_in = 1'b0; bus32.sub = 1'b0; bus32.out_ready = 1'b1;
        bus8.in_valid = 1'b0; bus8.a = 8'd0; bus8.b = 8'd0;
        bus8.c_in = 1'b0; bus8.sub = 1'b0; bus8.out_ready = 1'b1;

        // Reset state.
        #2 rst_n = 1'b0;
        #1;
        check("reset_state", {44'd0, bus16.out_valid, bus16.in_ready, bus16.c_out, bus16.ovf, bus16.sum},
              {44'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000});
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors, one at a time, with exact latency.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus16.in_valid = 1'b1;
            bus16.a = vecs[i].a; bus16.b = vecs[i].b;
            bus16.c_in = vecs[i].ci; bus16.sub = vecs[i].sb;
            @(negedge clk);
            bus16.in_valid = 1'b0;
            repeat (2) @(negedge clk);
            check($sformatf("vec%0d_not_early", i), {63'd0, bus16.out_valid}, 64'd0);
            @(negedge clk);
            check($sformatf("vec%0d", i),
                  {45'd0, bus16.out_valid, bus16.c_out, bus16.ovf, bus16.sum},
                  {45'd0, 1'b1, vecs[i].co, vecs[i].ov, vecs[i].s});
        end

        run_stream("stream", 300, 1'b0, 1'b0);
        run_stream("backpressure", 500, 1'b1, 1'b1);

        // Reset with beats in flight: one at the output, three behind it.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus16.in_valid = 1'b1;
            bus16.a = 16'(i + 1); bus16.b = 16'd0; bus16.c_in = 1'b0; bus16.sub = 1'b0;
        end
        @(negedge clk);
        bus16.in_valid = 1'b0;
        check("pre_reset_valid", {47'd0, bus16.out_valid, bus16.sum}, {47'd0, 1'b1, 16'h0001});
        #2 rst_n = 1'b0;
        #1;
        check("mid_reset_clear", {44'd0, bus16.out_valid, bus16.in_ready, bus16.c_out, bus16.ovf, bus16.sum},
              {44'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000});
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int seen = 0;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                if (bus16.out_valid) seen++;
            end
            check("flushed_beats_seen", 64'(seen), 64'd0);
        end
        bus16.in_valid = 1'b1;
        bus16.a = 16'h00AA; bus16.b = 16'h0011;
        @(negedge clk);
        bus16.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("post_reset_not_early", {63'd0, bus16.out_valid}, 64'd0);
        @(negedge clk);
        check("post_reset_beat", {47'd0, bus16.out_valid, bus16.sum}, {47'd0, 1'b1, 16'h00BB});

        // 32/8 (latency 4) and 8/8 (latency 1) against the reference model.
        for (int i = 0; i < 204; i++) begin
            @(negedge clk);
            if (i >= 4) begin
                check("w32_beat", {29'd0, bus32.out_valid, bus32.ovf, bus32.c_out, bus32.sum},
                      {29'd0, 1'b1, exp32[i-4]});
            end else begin
                check("w32_fill", {63'd0, bus32.out_valid}, 64'd0);
            end
            if (i >= 1 && i <= 200) begin
                check("w8_beat", {53'd0, bus8.out_valid, bus8.ovf, bus8.c_out, bus8.sum},
                      {53'd0, 1'b1, exp8[i-1]});
            end else begin
                check("w8_idle", {63'd0, bus8.out_valid}, 64'd0);
            end
            if (i < 200) begin
                logic [33:0] r8;
                bus32.in_valid = 1'b1;
                bus32.a = $urandom; bus32.b = $urandom;
                bus32.c_in = 1'($urandom_range(0, 1)); bus32.sub = 1'($urandom_range(0, 1));
                exp32[i] = ref_model(32, bus32.a, bus32.b, bus32.c_in, bus32.sub);
                bus8.in_valid = 1'b1;
                bus8.a = 8'($urandom); bus8.b = 8'($urandom);
                bus8.c_in = 1'($urandom_range(0, 1)); bus8.sub = 1'($urandom_range(0, 1));
                r8 = ref_model(8, {24'd0, bus8.a}, {24'd0, bus8.b}, bus8.c_in, bus8.sub);
                exp8[i] = {r8[33], r8[32], r8[7:0]};
            end else begin
                bus32.in_valid = 1'b0;
                bus8.in_valid  = 1'b0;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pipe_addsub.md
PIPE_ADDSUB -- requirements
Module: pipe_addsub

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning operand/result width in bits.
REQ-002 The block SHALL have parameter SEG, default 4, meaning bits added per pipeline stage; WIDTH SHALL be an integer multiple of SEG, and STAGES = WIDTH/SEG.
REQ-003 The block SHALL have port clk  input  1  the single clock, rising-edge active.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port in_valid  input  1  operand beat present.
REQ-006 The block SHALL have port in_ready  output  1  block accepts the beat this cycle.
REQ-007 The block SHALL have port a  input  WIDTH  first operand.
REQ-008 The block SHALL have port b  input  WIDTH  second operand.
REQ-009 The block SHALL have port c_in  input  1  carry-in (add) or borrow-in (sub).
REQ-010 The block SHALL have port sub  input  1  0 = add, 1 = subtract.
REQ-011 The block SHALL have port out_valid  output  1  result beat present.
REQ-012 The block SHALL have port out_ready  input  1  downstream accepts the result.
REQ-013 The block SHALL have port sum  output  WIDTH  result.
REQ-014 The block SHALL have port c_out  output  1  carry-out; for sub, 1 = no borrow.
REQ-015 The block SHALL have port ovf  output  1  two's-complement signed overflow.

Function
REQ-016 The block SHALL compute add: {c_out,sum} = a + b + c_in; sub: {c_out,sum} = a + ~b + ~c_in, i.e. a - b - c_in modulo 2^WIDTH.
REQ-017 The block SHALL set ovf = carry into MSB XOR carry out of MSB, both taken from the same beat.
REQ-018 The block SHALL form a STAGES-deep pipeline; stage k adds bits [k*SEG +: SEG] using the carry registered by stage k-1, and registers the partial sum, the carry and the untouched upper operand bits (b already conditionally inverted).
REQ-019 A beat SHALL be accepted on a rising edge with in_valid && in_ready; its result SHALL appear on out_valid/sum exactly STAGES cycles later when there is no stall (default latency 4).
REQ-020 Each stage SHALL hold a valid bit; the stall condition SHALL be out_valid && !out_ready.
REQ-021 While stalled, all stage registers SHALL hold, in_ready SHALL be 0, and sum/c_out/ovf SHALL remain stable.
REQ-022 When not stalled, in_ready SHALL be 1; bubbles (in_valid = 0) SHALL propagate as invalid stages, with no compaction.
REQ-023 Throughput SHALL be one beat per cycle with out_ready held high; no beat SHALL be dropped or duplicated; the output order SHALL equal the input order.
REQ-024 Operand, c_in and sub SHALL be sampled only on acceptance; changes while in_ready = 0 SHALL have no effect.
REQ-025 The output fields SHALL be don't-care when out_valid = 0, but SHALL NOT be X after reset.
REQ-026 When STAGES = 1, the block SHALL degenerate to one registered WIDTH-bit adder with latency 1.

Reset
REQ-027 rst_n low SHALL asynchronously clear all stage valid bits and data registers, giving out_valid = 0, sum = 0, c_out = 0 and ovf = 0; in_ready SHALL then be 1.
REQ-028 Reset asserted mid-operation SHALL discard all in-flight beats; the first beat accepted after rst_n rises SHALL emerge STAGES cycles later.

Verification
REQ-029 Add, default params: a = 16'hFFFF, b = 16'h0001, c_in = 0, sub = 0 -> 4 cycles later: sum = 16'h0000, c_out = 1, ovf = 0.
REQ-030 Sub: a = 16'h8000, b = 16'h0001, c_in = 0, sub = 1 -> sum = 16'h7FFF, c_out = 1, ovf = 1; a = 3, b = 5, sub = 1 -> sum = 16'hFFFE, c_out = 0.
REQ-031 Streaming: a = 0..299 with b = a>>2, one beat per cycle, out_ready = 1 -> 300 results in order, each equal to a+b, one per cycle after the 4-cycle fill.
REQ-032 Backpressure: out_ready toggled randomly for 500 beats -> no loss or duplication, in_ready = 0 exactly on stall cycles, and sum is stable during each stall.
REQ-033 Reset: rst_n pulsed low with 3 beats in flight -> out_valid = 0 immediately, and none of the 3 beats is ever output.
REQ-034 Parameters WIDTH = 32, SEG = 8 and WIDTH = 8, SEG = 8 -> an exhaustive or random reference-model compare passes, with latency 4 and 1 respectively.
